b2r_buffer_o: RTL and testbench

Block-to-row converter at the output side of the multi-MAC array; the inverse of the row-to-block input buffer. Accepts per beat NUM_CORES BLOCK_SIZE x BLOCK_SIZE result blocks, one per core, and reassembles them into full matrix rows of COL elements. Rows go to writeback/next layer one per beat. Ping-pong buffered so block ingest and row drain overlap.

---
 rtl/b2r_buffer_o_pkg.sv | 40 ++++
 rtl/b2r_buffer_o_bank.sv | 64 ++++++
 rtl/b2r_buffer_o.sv | 134 +++++++++++++
 tb/tb_b2r_buffer_o.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b2r_buffer_o_pkg.sv
// b2r_buffer_o_pkg: derived geometry helpers shared by the block-to-row
// output buffer and its bank, plus the element bit-offset helper also used
// by the row-to-block input buffer.
package b2r_buffer_o_pkg;

   // Blocks per block-row.
   function automatic int unsigned calc_bpr(input int unsigned col,
                                            input int unsigned block_size);
      return col / block_size;
   endfunction

   // Input beats per block-row (last beat may be partially used).
   function automatic int unsigned calc_beats(input int unsigned col,
                                              input int unsigned block_size,
                                              input int unsigned num_cores);
      return (col / block_size + num_cores - 1) / num_cores;
   endfunction

   // Block-rows per matrix.
   function automatic int unsigned calc_nbr(input int unsigned row,
                                            input int unsigned block_size);
      return row / block_size;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // LSB of element (row, col) in a flat vector of nelem elements laid out
   // row-major with ncols per row and element 0 in the MSBs.
   function automatic int unsigned elem_lsb(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned ncols,
                                            input int unsigned nelem,
                                            input int unsigned width);
      return (nelem - 1 - (row * ncols + col)) * width;
   endfunction

endpackage

// File: rtl/b2r_buffer_o_bank.sv
// b2r_buffer_o_bank: one ping-pong bank of BLOCK_SIZE rows x COL elements.
// Ports:
//   clk      clock
//   wr_en    per-core block write enable for the current beat
//   wr_beat  beat index within the block-row (selects block columns)
//   wr_data  NUM_CORES blocks, core 0 in MSBs, element (r,c) at r*BLOCK_SIZE+c
//   rd_row   row within the bank to present
//   rd_data  selected row, column 0 in MSBs
module b2r_buffer_o_bank
   import b2r_buffer_o_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned BLOCK_SIZE = 2,
   parameter int unsigned CHUNK_SIZE = 4,
   parameter int unsigned COL        = 6,
   parameter int unsigned NUM_CORES  = 2,
   localparam int unsigned BEAT_W    = cnt_width(calc_beats(COL, BLOCK_SIZE, NUM_CORES)),
   localparam int unsigned RROW_W    = cnt_width(BLOCK_SIZE),
   localparam int unsigned IN_W      = WIDTH * CHUNK_SIZE * NUM_CORES
)(
   input  logic                   clk,
   input  logic [NUM_CORES-1:0]   wr_en,
   input  logic [BEAT_W-1:0]      wr_beat,
   input  logic [IN_W-1:0]        wr_data,
   input  logic [RROW_W-1:0]      rd_row,
   output logic [WIDTH*COL-1:0]   rd_data
);

   localparam int unsigned COL_W = cnt_width(COL);

   logic [WIDTH-1:0] mem [BLOCK_SIZE][COL];
   logic [COL_W-1:0] wcol_base [NUM_CORES];

   // First element column of the block each core carries on this beat.
   always_comb begin
      for (int k = 0; k < NUM_CORES; k++) begin
         wcol_base[k] = COL_W'((int'(wr_beat) * NUM_CORES + k) * BLOCK_SIZE);
      end
   end

   // Block write: scatter each enabled core's block into its column window.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CORES; k++) begin
         if (wr_en[k]) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
               for (int c = 0; c < BLOCK_SIZE; c++) begin
                  mem[r][wcol_base[k] + COL_W'(c)] <=
                     wr_data[elem_lsb(r, c, BLOCK_SIZE, NUM_CORES * CHUNK_SIZE, WIDTH)
                             - k * CHUNK_SIZE * WIDTH +: WIDTH];
               end
            end
         end
      end
   end

   // Row read.
   always_comb begin
      rd_data = '0;
      for (int c = 0; c < COL; c++) begin
         rd_data[elem_lsb(0, c, COL, COL, WIDTH) +: WIDTH] = mem[rd_row][c];
      end
   end

endmodule

// File: rtl/b2r_buffer_o.sv
// b2r_buffer_o: reassembles NUM_CORES result blocks per beat into full matrix
// rows, ping-pong buffered so block ingest overlaps row drain.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   input beat handshake
//   in_b2r_buffer    NUM_CORES blocks, core 0 in MSBs
//   out_valid/ready  output row handshake
//   out_b2r_buffer   one matrix row, column 0 in MSBs
//   out_last         final row of the matrix
//   frame_done       pulse the cycle after the out_last handshake
module b2r_buffer_o
   import b2r_buffer_o_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned BLOCK_SIZE = 2,
   parameter int unsigned CHUNK_SIZE = 4,
   parameter int unsigned ROW        = 8,
   parameter int unsigned COL        = 6,
   parameter int unsigned NUM_CORES  = 2
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_b2r_buffer,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [WIDTH*COL-1:0]                 out_b2r_buffer,
   output logic                                 out_last,
   output logic                                 frame_done
);

   localparam int unsigned BPR    = calc_bpr(COL, BLOCK_SIZE);
   localparam int unsigned BEATS  = calc_beats(COL, BLOCK_SIZE, NUM_CORES);
   localparam int unsigned NBR    = calc_nbr(ROW, BLOCK_SIZE);
   localparam int unsigned BEAT_W = cnt_width(BEATS);
   localparam int unsigned RROW_W = cnt_width(BLOCK_SIZE);
   localparam int unsigned BROW_W = cnt_width(NBR);

   logic                 wbank;
   logic                 rbank;
   logic [1:0]           full;
   logic [BEAT_W-1:0]    beat_cnt;
   logic [BROW_W-1:0]    wbrow_cnt;
   logic [RROW_W-1:0]    rrow_cnt;
   logic [BROW_W-1:0]    rbrow_cnt;

   logic                 in_fire_c;
   logic                 out_fire_c;
   logic                 last_beat_c;
   logic                 last_row_c;
   logic [NUM_CORES-1:0] core_valid_c;
   logic [NUM_CORES-1:0] wr_en_c [2];
   logic [WIDTH*COL-1:0] rd_data_c [2];

   // Handshake status derives from registered flags only.
   assign in_ready       = !full[wbank];
   assign out_valid      = full[rbank];
   assign out_b2r_buffer = rd_data_c[rbank];
   assign in_fire_c      = in_valid && in_ready;
   assign out_fire_c     = out_valid && out_ready;
   assign last_beat_c    = (beat_cnt == BEAT_W'(BEATS - 1));
   assign last_row_c     = (rrow_cnt == RROW_W'(BLOCK_SIZE - 1));
   assign out_last       = out_valid && last_row_c && (rbrow_cnt == BROW_W'(NBR - 1));

   // Cores whose block column lies past the matrix edge are dropped.
   always_comb begin
      core_valid_c = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         core_valid_c[k] = (int'(beat_cnt) * int'(NUM_CORES) + k) < int'(BPR);
      end
   end

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         wr_en_c[b] = (in_fire_c && (wbank == 1'(b))) ? core_valid_c : '0;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      b2r_buffer_o_bank #(
         .WIDTH      (WIDTH),
         .BLOCK_SIZE (BLOCK_SIZE),
         .CHUNK_SIZE (CHUNK_SIZE),
         .COL        (COL),
         .NUM_CORES  (NUM_CORES)
      ) u_bank (
         .clk     (clk),
         .wr_en   (wr_en_c[b]),
         .wr_beat (beat_cnt),
         .wr_data (in_b2r_buffer),
         .rd_row  (rrow_cnt),
         .rd_data (rd_data_c[b])
      );
   end

   // Writer/reader control. Set and clear never target the same flag since
   // a full bank cannot be written and an empty bank cannot be drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbank      <= 1'b0;
         rbank      <= 1'b0;
         full       <= '0;
         beat_cnt   <= '0;
         wbrow_cnt  <= '0;
         rrow_cnt   <= '0;
         rbrow_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_fire_c && out_last;
         if (in_fire_c) begin
            if (last_beat_c) begin
               full[wbank] <= 1'b1;
               wbank       <= ~wbank;
               beat_cnt    <= '0;
               wbrow_cnt   <= (wbrow_cnt == BROW_W'(NBR - 1)) ? '0 : wbrow_cnt + BROW_W'(1);
            end else begin
               beat_cnt    <= beat_cnt + BEAT_W'(1);
            end
         end
         if (out_fire_c) begin
            if (last_row_c) begin
               full[rbank] <= 1'b0;
               rbank       <= ~rbank;
               rrow_cnt    <= '0;
               rbrow_cnt   <= (rbrow_cnt == BROW_W'(NBR - 1)) ? '0 : rbrow_cnt + BROW_W'(1);
            end else begin
               rrow_cnt    <= rrow_cnt + RROW_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_b2r_buffer_o.sv
// tb_b2r_buffer_o: scoreboard bench for b2r_buffer_o (default geometry plus
// a COL=8 instance). Stimulus pushes expected rows; monitors pop on handshake.
module tb_b2r_buffer_o;

   localparam int unsigned W  = 16;
   localparam int unsigned BS = 2;
   localparam int unsigned CS = 4;
   localparam int unsigned R  = 8;
   localparam int unsigned C  = 6;
   localparam int unsigned C8 = 8;
   localparam int unsigned NC = 2;
   localparam int unsigned IN_W = W * CS * NC;

   typedef struct packed {
      logic [127:0] data;
      logic         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
   logic [IN_W-1:0]  in_data;
   logic [W*C-1:0]   out_data;
   logic in_valid8, in_ready8, out_valid8, out_ready8, out_last8, frame_done8;
   logic [IN_W-1:0]  in_data8;
   logic [W*C8-1:0]  out_data8;

   exp_t sb[$];
   exp_t sb8[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ready_low = 0;
   int   cyc = 0;
   int   first_hs8 = -1;
   int   last_hs8 = -1;
   bit   mon_en = 1'b0;
   bit   rand_ready = 1'b0;
   logic fd_exp = 1'b0;
   logic fd_exp8 = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   b2r_buffer_o #(.WIDTH(W), .BLOCK_SIZE(BS), .CHUNK_SIZE(CS), .ROW(R), .COL(C), .NUM_CORES(NC)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_b2r_buffer(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_b2r_buffer(out_data),
      .out_last(out_last), .frame_done(frame_done));

   b2r_buffer_o #(.WIDTH(W), .BLOCK_SIZE(BS), .CHUNK_SIZE(CS), .ROW(R), .COL(C8), .NUM_CORES(NC)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_b2r_buffer(in_data8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_b2r_buffer(out_data8),
      .out_last(out_last8), .frame_done(frame_done8));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Matrix element value for frame f, element (i,j) of a ncol-wide matrix.
   function automatic logic [15:0] mval(input int f, input int i, input int j, input int ncol);
      int v;
      v = (f * 48 + ncol * i + j) * 256;
      return 16'(v);
   endfunction

   function automatic logic [127:0] build_beat(input int f, input int br, input int b, input int ncol);
      logic [127:0] d;
      int bc;
      d = '0;
      for (int k = 0; k < 2; k++) begin
         bc = b * 2 + k;
         for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
               d[127 - (k * 4 + r * 2 + c) * 16 -: 16] =
                  (bc < ncol / 2) ? mval(f, br * 2 + r, bc * 2 + c, ncol) : 16'hFFFF;
            end
         end
      end
      return d;
   endfunction

   function automatic logic [127:0] exp_row(input int f, input int i, input int ncol);
      logic [127:0] d;
      d = '0;
      for (int j = 0; j < ncol; j++) d[ncol * 16 - 1 - j * 16 -: 16] = mval(f, i, j, ncol);
      return d;
   endfunction

   // Called at posedge+1; returns at posedge+1 just after acceptance.
   task automatic send_beat(input bit sel, input logic [127:0] d);
      int waited;
      waited = 0;
      if (sel) begin in_data8 = d; in_valid8 = 1'b1; end
      else     begin in_data  = d; in_valid  = 1'b1; end
      @(negedge clk);
      while (((sel ? in_ready8 : in_ready) !== 1'b1) && waited < 300) begin
         ready_low++;
         waited++;
         @(negedge clk);
      end
      if (waited >= 300) begin
         n_cmp++; n_bad++;
         $display("FAIL in_ready_timeout: got in_ready low for %0d cycles expected acceptance", waited);
      end
      @(posedge clk); #1;
      if (sel) in_valid8 = 1'b0; else in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_brow(input int f, input int br, input bit gaps);
      for (int r = 0; r < 2; r++) begin
         exp_t e;
         e.data = exp_row(f, br * 2 + r, C);
         e.last = (br == 3) && (r == 1);
         sb.push_back(e);
      end
      for (int b = 0; b < 2; b++) begin
         if (gaps) idle($urandom_range(0, 2));
         send_beat(1'b0, build_beat(f, br, b, C));
      end
   endtask

   task automatic send_frame(input int f, input bit gaps);
      for (int br = 0; br < 4; br++) send_brow(f, br, gaps);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      do begin @(posedge clk); n++; end while ((sb.size() != 0 || sb8.size() != 0) && n < 600);
      #1;
      chk(name, 128'(sb.size() + sb8.size()), 128'(0));
      sb.delete();
      sb8.delete();
      idle(2);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      sb.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   always @(posedge clk) if (rand_ready) begin #1; out_ready = 1'($urandom_range(0, 1)); end

   // Monitor for the default-geometry instance.
   always @(negedge clk) begin
      exp_t e;
      if (!mon_en) fd_exp = 1'b0;
      else begin
         chk("frame_done", 128'(frame_done), 128'(fd_exp));
         fd_exp = 1'b0;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_row: got %h expected no row", out_data);
            end else begin
               e = sb.pop_front();
               chk("row_data", 128'(out_data), e.data);
               chk("row_last", 128'(out_last), 128'(e.last));
               fd_exp = e.last;
            end
         end
      end
   end

   // Monitor for the COL=8 instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst !== 1'b1) begin
         chk("frame_done8", 128'(frame_done8), 128'(fd_exp8));
         fd_exp8 = 1'b0;
         if (out_valid8 && out_ready8) begin
            if (sb8.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_row8: got %h expected no row", out_data8);
            end else begin
               e = sb8.pop_front();
               chk("row_data8", out_data8, e.data);
               chk("row_last8", 128'(out_last8), 128'(e.last));
               fd_exp8 = e.last;
               if (first_hs8 < 0) first_hs8 = cyc;
               last_hs8 = cyc;
            end
         end
      end
   end

   initial begin
      exp_t e;
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      chk("rst_frame_done", 128'(frame_done), 128'(0));

      // Hand-computed first block-row, core 1 garbage on the partial beat.
      mon_en = 1'b1;
      out_ready = 1'b1;
      e.data = 128'(96'h0000_0100_0200_0300_0400_0500); e.last = 1'b0; sb.push_back(e);
      e.data = 128'(96'h0600_0700_0800_0900_0A00_0B00); e.last = 1'b0; sb.push_back(e);
      send_beat(1'b0, 128'h0000_0100_0600_0700_0200_0300_0800_0900);
      chk("lat_out_valid_pre", 128'(out_valid), 128'(0));
      send_beat(1'b0, 128'h0400_0500_0A00_0B00_FFFF_FFFF_FFFF_FFFF);
      chk("lat_out_valid_post", 128'(out_valid), 128'(1));
      wait_drain("drain_directed");

      // Full frame, continuous input and ready.
      do_reset();
      mon_en = 1'b1;
      ready_low = 0;
      send_frame(0, 1'b0);
      chk("in_ready_never_low", 128'(ready_low), 128'(0));
      wait_drain("drain_frame0");

      // Backpressure: both banks fill, then drain releases bank 0.
      out_ready = 1'b0;
      send_brow(1, 0, 1'b0);
      send_brow(1, 1, 1'b0);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_row0", 128'(out_data), exp_row(1, 0, C));
      idle(3);
      chk("bp_row0_hold", 128'(out_data), exp_row(1, 0, C));
      chk("bp_in_ready_hold", 128'(in_ready), 128'(0));
      out_ready = 1'b1;
      @(negedge clk); chk("bp_rel_0", 128'(in_ready), 128'(0));
      @(negedge clk); chk("bp_rel_1", 128'(in_ready), 128'(0));
      @(negedge clk); chk("bp_rel_2", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      send_brow(1, 2, 1'b0);
      send_brow(1, 3, 1'b0);
      wait_drain("drain_frame1");

      // Random ready and input gaps over three frames.
      rand_ready = 1'b1;
      for (int f = 2; f < 5; f++) send_frame(f, 1'b1);
      rand_ready = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain("drain_random");

      // Mid-frame reset discards the partial frame.
      mon_en = 1'b0;
      out_ready = 1'b0;
      send_beat(1'b0, build_beat(3, 0, 0, C));
      send_beat(1'b0, build_beat(3, 0, 1, C));
      send_beat(1'b0, build_beat(3, 1, 0, C));
      do_reset();
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
      chk("mid_rst_out_last", 128'(out_last), 128'(0));
      chk("mid_rst_frame_done", 128'(frame_done), 128'(0));
      mon_en = 1'b1;
      out_ready = 1'b1;
      send_frame(0, 1'b0);
      wait_drain("drain_after_rst");
      idle(5);
      chk("no_stale_rows", 128'(out_valid), 128'(0));

      // COL=8, no partial beat: full frame with no output bubble.
      ready_low = 0;
      out_ready8 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         e.data = exp_row(0, i, C8);
         e.last = (i == 7);
         sb8.push_back(e);
      end
      for (int br = 0; br < 4; br++)
         for (int b = 0; b < 2; b++) send_beat(1'b1, build_beat(0, br, b, C8));
      wait_drain("drain_col8");
      chk("col8_in_ready_never_low", 128'(ready_low), 128'(0));
      chk("col8_no_bubble", 128'(last_hs8 - first_hs8), 128'(7));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
